// File: rtl/cpu_bus_master_arb.sv
// Round-robin master for the shared CPU configuration bus: one complete
// Intel- or Motorola-style bus cycle per grant, with strobe/ack timeout.
module cpu_bus_master_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 24,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_mode_cfg,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic [DW-1:0]    rdata,
    output logic             BusMode,
    output logic [AW-1:0]    Addr,
    output logic             Sel,
    output logic [DW-1:0]    DataIn,
    input  logic [DW-1:0]    DataOut,
    output logic             Rd_DS,
    output logic             Wr_RW,
    input  logic             Rdy_Dtack
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic            mode_q, mode_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            found;

    assign cnt_inc = cnt_q + 1'b1;

    // First pending requester at or after the pointer, wrapping upward.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((ptr_q + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            mode_q  <= 1'b1;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        mode_d  = mode_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << pick;
                    addr_d  = req_addr[pick*AW +: AW];
                    wdata_d = req_wdata[pick*DW +: DW];
                    we_d    = req_we[pick];
                    mode_d  = bus_mode_cfg;
                    ptr_d   = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (!Rdy_Dtack) begin
                    if (!we_q) begin
                        rdata_d = DataOut;
                    end
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = RECOVER;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RECOVER: begin
                if (Rdy_Dtack || (cnt_inc == CW'(TIMEOUT))) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Sel   = 1'b1;
        Rd_DS = 1'b1;
        Wr_RW = 1'b1;
        unique case (state_q)
            SETUP: begin
                Sel   = 1'b0;
                Wr_RW = mode_q ? 1'b1 : ~we_q;
            end
            STROBE: begin
                Sel = 1'b0;
                if (mode_q) begin
                    if (we_q) begin
                        Wr_RW = 1'b0;
                    end else begin
                        Rd_DS = 1'b0;
                    end
                end else begin
                    Rd_DS = 1'b0;
                    Wr_RW = ~we_q;
                end
            end
            default: ;
        endcase
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign BusMode = mode_q;
    assign Addr    = addr_q;
    assign DataIn  = wdata_q;

endmodule

// File: tb/tb_cpu_bus_master_arb.sv
// Bench for cpu_bus_master_arb: transaction-timeline model with a reactive
// peripheral, directed scenarios pinned by literals, then random traffic.
module tb_cpu_bus_master_arb;

    localparam int NREQ = 2;
    localparam int DW   = 16;
    localparam int AW   = 24;
    localparam int TO   = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 bus_mode_cfg;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [DW-1:0]        rdata;
    logic                 BusMode;
    logic [AW-1:0]        Addr;
    logic                 Sel;
    logic [DW-1:0]        DataIn;
    logic [DW-1:0]        DataOut;
    logic                 Rd_DS;
    logic                 Wr_RW;
    logic                 Rdy_Dtack;

    cpu_bus_master_arb #(
        .NREQ(NREQ),
        .DW(DW),
        .AW(AW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_mode_cfg(bus_mode_cfg),
        .req(req),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .gnt(gnt),
        .done(done),
        .err(err),
        .rdata(rdata),
        .BusMode(BusMode),
        .Addr(Addr),
        .Sel(Sel),
        .DataIn(DataIn),
        .DataOut(DataOut),
        .Rd_DS(Rd_DS),
        .Wr_RW(Wr_RW),
        .Rdy_Dtack(Rdy_Dtack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: one transaction described by its strobe length S and recover length R.
    bit            m_busy, m_tmo, m_we, m_mode;
    int            m_t, m_S, m_R, m_cur, m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    // Peripheral behaviour for the current transaction.
    int            p_ack, p_rel, pc, rc;
    bit            acked;
    logic [DW-1:0] p_data;
    int            f_ack = -1, f_rel = -1, f_data = -1;

    bit            rand_req = 1'b0;
    bit [NREQ-1:0] pend;

    int            r_steps, r_sel_low, r_rd_low, r_wr_low;
    bit            r_got, r_err, r_mode, r_sel;
    logic [NREQ-1:0] r_done;
    logic [DW-1:0] r_rdata, r_wdata;
    logic [AW-1:0] r_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_tmo = 0; m_we = 0; m_mode = 1;
        m_t = 0; m_S = 0; m_R = 0; m_cur = 0; m_ptr = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic periph_reset();
        pc = 0; rc = 0; acked = 0; Rdy_Dtack = 1'b1;
    endtask

    task automatic compare();
        logic [NREQ-1:0] e_gnt, e_done, oh;
        logic e_err, e_sel, e_rd, e_wr;
        e_gnt = '0; e_done = '0; e_err = 0; e_sel = 1; e_rd = 1; e_wr = 1;
        oh = NREQ'(1) << m_cur;
        if (m_busy) begin
            if (m_t == 0) begin
                e_gnt = oh; e_sel = 0; e_wr = m_mode ? 1'b1 : ~m_we;
            end else if (m_t <= m_S) begin
                e_gnt = oh; e_sel = 0;
                if (m_mode) begin
                    if (m_we) e_wr = 0; else e_rd = 0;
                end else begin
                    e_rd = 0; e_wr = ~m_we;
                end
            end else if (m_t == m_S + 1) begin
                e_done = oh; e_err = m_tmo;
            end
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("Sel", 32'(Sel), 32'(e_sel));
        chk("Rd_DS", 32'(Rd_DS), 32'(e_rd));
        chk("Wr_RW", 32'(Wr_RW), 32'(e_wr));
        chk("BusMode", 32'(BusMode), 32'(m_mode));
        chk("Addr", 32'(Addr), 32'(m_addr));
        chk("DataIn", 32'(DataIn), 32'(m_wdata));
        chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic periph_update();
        bit strobe;
        strobe = !Sel && (!Rd_DS || (BusMode && !Wr_RW));
        if (!Sel && !strobe) begin
            pc = 0; rc = 0; acked = 0; Rdy_Dtack = 1'b1;
        end else if (strobe) begin
            pc++;
            if (pc >= p_ack) begin
                Rdy_Dtack = 1'b0; acked = 1;
            end else begin
                Rdy_Dtack = 1'b1;
            end
        end else begin
            if (rc < 1000) rc++;
            Rdy_Dtack = (!acked || rc > p_rel) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic req_update();
        for (int i = 0; i < NREQ; i++) begin
            if (done[i]) begin
                pend[i] = 0; req[i] = 1'b0;
            end else if (pend[i]) begin
                if (gnt[i] && $urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                pend[i] = 1; req[i] = 1'b1;
                req_we[i] = 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW] = AW'($urandom);
                req_wdata[i*DW +: DW] = DW'($urandom);
            end
        end
        bus_mode_cfg = 1'($urandom_range(0, 1));
    endtask

    task automatic model_advance();
        bit found;
        int idx;
        if (!m_busy) begin
            if (req != '0) begin
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (!found && req[idx]) begin
                        found = 1; m_cur = idx;
                    end
                end
                m_ptr   = (m_cur + 1) % NREQ;
                m_busy  = 1; m_t = 0;
                m_we    = req_we[m_cur];
                m_addr  = req_addr[m_cur*AW +: AW];
                m_wdata = req_wdata[m_cur*DW +: DW];
                m_mode  = bus_mode_cfg;
                p_ack   = (f_ack >= 0) ? f_ack : $urandom_range(1, TO + 2);
                if (f_rel >= 0) p_rel = f_rel;
                else if ($urandom_range(0, 9) == 0) p_rel = $urandom_range(TO - 1, TO + 5);
                else p_rel = $urandom_range(0, 3);
                p_data  = (f_data >= 0) ? DW'(f_data) : DW'($urandom);
                DataOut = p_data;
                m_tmo   = p_ack > TO;
                m_S     = m_tmo ? TO : p_ack;
                m_R     = m_tmo ? 1 : ((p_rel + 1 < TO) ? p_rel + 1 : TO);
            end
        end else begin
            if (m_t == m_S && !m_we && !m_tmo) m_rdata = p_data;
            if (m_t == m_S + m_R) m_busy = 0;
            else m_t++;
        end
    endtask

    task automatic step();
        periph_update();
        if (rand_req) req_update();
        model_advance();
        @(negedge clk);
        compare();
    endtask

    task automatic run_txn(input int budget, input bit keep, input bit flip);
        r_steps = 0; r_sel_low = 0; r_rd_low = 0; r_wr_low = 0; r_got = 0;
        while (!r_got && r_steps < budget) begin
            step();
            r_steps++;
            if (!Sel) begin
                r_sel_low++; r_addr = Addr; r_wdata = DataIn;
            end
            if (!Rd_DS) r_rd_low++;
            if (!Wr_RW) r_wr_low++;
            if (flip && gnt != '0) bus_mode_cfg = 1'b1;
            if (done != '0) begin
                r_got = 1; r_done = done; r_err = err; r_rdata = rdata;
                r_mode = BusMode; r_sel = Sel;
                if (!keep) req = req & ~done;
            end
        end
        chk("txn_done_seen", 32'(r_got), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        int nd;
        rst_n = 1'b0; bus_mode_cfg = 1'b1; req = '0; req_we = '0;
        req_addr = '0; req_wdata = '0; DataOut = '0; pend = '0;
        p_ack = 1; p_rel = 0; p_data = '0;
        periph_reset();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_Sel", 32'(Sel), 32'd1);
        chk("rst_Rd_DS", 32'(Rd_DS), 32'd1);
        chk("rst_Wr_RW", 32'(Wr_RW), 32'd1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_BusMode", 32'(BusMode), 32'd1);
        chk("rst_Addr", 32'(Addr), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        compare();
        rst_n = 1'b1;

        // Intel write from requester 0.
        bus_mode_cfg = 1'b1; req_we = 2'b01;
        req_addr[0 +: AW] = 24'h000123; req_wdata[0 +: DW] = 16'hA5C3;
        f_ack = 3; f_rel = 0; req = 2'b01;
        run_txn(30, 0, 0);
        chk("iw_sel_low", 32'(r_sel_low), 32'd4);
        chk("iw_wr_low", 32'(r_wr_low), 32'd3);
        chk("iw_rd_low", 32'(r_rd_low), 32'd0);
        chk("iw_done", 32'(r_done), 32'h1);
        chk("iw_err", 32'(r_err), 32'd0);
        chk("iw_addr", 32'(r_addr), 32'h000123);
        chk("iw_wdata", 32'(r_wdata), 32'hA5C3);

        // Motorola read from requester 1; cfg flips mid-cycle and must be ignored.
        bus_mode_cfg = 1'b0; req_we = 2'b00;
        req_addr[AW +: AW] = 24'h00FFFE;
        f_ack = 2; f_rel = 1; f_data = 16'h1E2D; req = 2'b10;
        run_txn(30, 0, 1);
        chk("mr_busmode", 32'(r_mode), 32'd0);
        chk("mr_wr_low", 32'(r_wr_low), 32'd0);
        chk("mr_rd_low", 32'(r_rd_low), 32'd2);
        chk("mr_rdata", 32'(r_rdata), 32'h1E2D);
        chk("mr_done", 32'(r_done), 32'h2);
        chk("mr_err", 32'(r_err), 32'd0);

        // Round robin with both requesting continuously.
        bus_mode_cfg = 1'b1; f_ack = 1; f_rel = 0; f_data = 16'h5A5A; req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            run_txn(30, 1, 0);
            chk("rr_order", 32'(r_done), (n % 2 == 0) ? 32'h1 : 32'h2);
            if (n > 0) chk("rr_gap", 32'(r_steps), 32'd4);
        end
        req = 2'b00;

        // Timeout: no ack at all.
        req_addr[0 +: AW] = 24'h0ABCDE; f_ack = 100; f_data = 16'hDEAD; req = 2'b01;
        run_txn(60, 0, 0);
        chk("to_rd_low", 32'(r_rd_low), 32'd15);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_rdata", 32'(r_rdata), 32'h5A5A);
        chk("to_sel", 32'(r_sel), 32'd1);
        chk("to_done", 32'(r_done), 32'h1);

        // Ack in the last allowed strobe cycle.
        f_ack = 15; f_data = 16'h7E57; req = 2'b01;
        run_txn(60, 0, 0);
        chk("edge_rd_low", 32'(r_rd_low), 32'd15);
        chk("edge_err", 32'(r_err), 32'd0);
        chk("edge_rdata", 32'(r_rdata), 32'h7E57);

        // Reset in the middle of a strobe, pointer left at 1 beforehand.
        req_we = 2'b01; req_addr[0 +: AW] = 24'h654321; req_wdata[0 +: DW] = 16'h1357;
        f_ack = 10; f_rel = 0; req = 2'b01;
        seen = 0;
        for (int n = 0; n < 20 && seen < 2; n++) begin
            step();
            if (!Wr_RW) seen++;
        end
        chk("rst_mid_reached", 32'(seen), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_Sel", 32'(Sel), 32'd1);
        chk("rstm_Wr_RW", 32'(Wr_RW), 32'd1);
        chk("rstm_Rd_DS", 32'(Rd_DS), 32'd1);
        chk("rstm_gnt", 32'(gnt), 32'd0);
        chk("rstm_done", 32'(done), 32'd0);
        chk("rstm_Addr", 32'(Addr), 32'd0);
        req = 2'b00;
        @(negedge clk);
        model_reset();
        periph_reset();
        compare();
        rst_n = 1'b1;
        step();
        req_we = 2'b00; f_ack = 1; req = 2'b11;
        run_txn(20, 0, 0);
        chk("rstm_first_grant", 32'(r_done), 32'h1);
        req = 2'b00;

        // Random traffic.
        f_ack = -1; f_rel = -1; f_data = -1; pend = '0; rand_req = 1'b1;
        nd = 0;
        for (int n = 0; n < 2500; n++) begin
            step();
            if (done != '0) nd++;
        end
        chk("rand_activity", 32'(nd >= 50), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
